// File: rtl/reg_file_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Latency: n/a (declarations only).
// Backpressure: n/a; consumers stall on the hazard flags instead.
package reg_file_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 32;

   // Width needed to hold a count of 0..depth pending registers.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef logic [$clog2(DEF_DEPTH)-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: one bit per register, hazard flags per read port, pending count.
// Latency: hazards combinational from pending state; pend_cnt lags pending by one cycle.
// Backpressure: none internal; haz1/haz2 tell the pipeline to stall the reader.
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int CNT_W    = cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iss,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic              haz1,
   output logic              haz2,
   output logic [CNT_W-1:0]  pend_cnt
);

   localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];

   logic [DEPTH-1:0] pend_q, pend_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // An address names a real, writable register (not out of range, not the zero register).
   function automatic logic live(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_V) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Writeback clears, a new issue sets; the issue is applied last so it wins on the same bit.
   always_comb begin
      pend_d = pend_q;
      if (we && live(wa)) pend_d[wa] = 1'b0;
      if (iss && live(iss_addr)) pend_d[iss_addr] = 1'b1;
   end

   // Population count of the current pending vector, registered into pend_cnt.
   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + CNT_W'(pend_q[i]);
   end

   // A pending read is not a hazard when the forwarded writeback satisfies it this cycle.
   always_comb begin
      haz1 = live(ra1) && pend_q[ra1] && !((BYPASS != 0) && we && (wa == ra1));
      haz2 = live(ra2) && pend_q[ra2] && !((BYPASS != 0) && we && (wa == ra2));
   end

   // Pending vector and count state; reset drops every in-flight load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pend_cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with write-to-read bypass and a pending-load scoreboard.
// Latency: reads combinational; writes land on the clock edge; pend_cnt is registered.
// Backpressure: none; readers stall themselves on haz1/haz2.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              haz1,
   output logic              haz2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic              iss,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic [ADDR_W:0]   pend_cnt
);

   localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic              byp1, byp2;

   // Readable/writable storage: in range and not the hardwired zero register.
   function automatic logic live(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_V) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Write decode: only live addresses are updated.
   always_comb begin
      regs_d = regs_q;
      if (we && live(wa)) regs_d[wa] = wd;
   end

   // Storage array, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) regs_q <= '{default: '0};
      else        regs_q <= regs_d;
   end

   // Read muxes; bypass is held off during reset so reads are zero while reset is active.
   always_comb begin
      byp1 = (BYPASS != 0) && rst_n && we && (wa == ra1);
      byp2 = (BYPASS != 0) && rst_n && we && (wa == ra2);
      rd1  = '0;
      rd2  = '0;
      if (live(ra1)) rd1 = byp1 ? wd : regs_q[ra1];
      if (live(ra2)) rd2 = byp2 ? wd : regs_q[ra2];
   end

   reg_scoreboard #(
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
   ) u_sb (
      .clk     (clk),
      .rst_n   (rst_n),
      .iss     (iss),
      .iss_addr(iss_addr),
      .we      (we),
      .wa      (wa),
      .ra1     (ra1),
      .ra2     (ra2),
      .haz1    (haz1),
      .haz2    (haz2),
      .pend_cnt(pend_cnt)
   );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: table vectors, corner sequences and a random run against a model.
// Two instances: A (DEPTH 32, zero reg, bypass) and B (DEPTH 24, no zero reg, no bypass).
// Inputs change 1 time unit after the rising edge; outputs are checked 3 units after it.
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  ra1, ra2, wa, iss_addr;
   logic        we, iss;
   logic [31:0] wd;

   logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
   logic        haz1_a, haz2_a, haz1_b, haz2_b;
   logic [5:0]  cnt_a, cnt_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
      .haz1(haz1_a), .haz2(haz2_a), .we(we), .wa(wa), .wd(wd), .iss(iss),
      .iss_addr(iss_addr), .pend_cnt(cnt_a));

   reg_file_sb #(.DATA_W(32), .DEPTH(24), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
      .haz1(haz1_b), .haz2(haz2_b), .we(we), .wa(wa), .wd(wd), .iss(iss),
      .iss_addr(iss_addr), .pend_cnt(cnt_b));

   // ---------------- reference model ----------------
   logic [31:0] mr [2][32];
   bit          mp [2][32];
   int          mc [2];

   function automatic int dep(input int k); return (k == 0) ? 32 : 24; endfunction
   function automatic int zr(input int k);  return (k == 0) ? 1 : 0;   endfunction
   function automatic int byp(input int k); return (k == 0) ? 1 : 0;   endfunction

   function automatic bit live(input int k, input int a);
      return (a < dep(k)) && !(zr(k) == 1 && a == 0);
   endfunction

   function automatic logic [31:0] m_rd(input int k, input int ra);
      if (!live(k, ra)) return '0;
      if (byp(k) == 1 && rst_n && we && int'(wa) == ra) return wd;
      return mr[k][ra];
   endfunction

   function automatic bit m_haz(input int k, input int ra);
      if (!live(k, ra)) return 1'b0;
      if (byp(k) == 1 && we && int'(wa) == ra) return 1'b0;
      return mp[k][ra];
   endfunction

   function automatic void m_reset();
      for (int k = 0; k < 2; k++) begin
         mc[k] = 0;
         for (int a = 0; a < 32; a++) begin
            mr[k][a] = '0;
            mp[k][a] = 1'b0;
         end
      end
   endfunction

   // One clock edge: count is the population of pending before this edge's update.
   function automatic void m_step(input int k);
      int n;
      if (!rst_n) return;
      n = 0;
      for (int a = 0; a < 32; a++) n += int'(mp[k][a]);
      mc[k] = n;
      if (we && live(k, int'(wa))) begin
         mr[k][wa] = wd;
         mp[k][wa] = 1'b0;
      end
      if (iss && live(k, int'(iss_addr))) mp[k][iss_addr] = 1'b1;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("a_rd1",  rd1_a,       m_rd(0, int'(ra1)));
      chk("a_rd2",  rd2_a,       m_rd(0, int'(ra2)));
      chk("a_haz1", 32'(haz1_a), 32'(m_haz(0, int'(ra1))));
      chk("a_haz2", 32'(haz2_a), 32'(m_haz(0, int'(ra2))));
      chk("a_cnt",  32'(cnt_a),  mc[0]);
      chk("b_rd1",  rd1_b,       m_rd(1, int'(ra1)));
      chk("b_rd2",  rd2_b,       m_rd(1, int'(ra2)));
      chk("b_haz1", 32'(haz1_b), 32'(m_haz(1, int'(ra1))));
      chk("b_haz2", 32'(haz2_b), 32'(m_haz(1, int'(ra2))));
      chk("b_cnt",  32'(cnt_b),  mc[1]);
   endtask

   task automatic tick();
      @(posedge clk);
      m_step(0);
      m_step(1);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; iss = 1'b0; wa = '0; wd = '0; iss_addr = '0;
   endtask

   // ---------------- directed vectors for instance A ----------------
   typedef struct {
      bit          we;
      logic [4:0]  wa;
      logic [31:0] wd;
      bit          iss;
      logic [4:0]  ia;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] e_rd1;
      bit          e_h1;
      logic [31:0] e_rd2;
      bit          e_h2;
      int          e_cnt;
   } vec_t;

   function automatic vec_t mk(input int w, input int a, input logic [31:0] d,
                               input int s, input int ia, input int r1, input int r2,
                               input logic [31:0] e1, input int h1,
                               input logic [31:0] e2, input int h2, input int c);
      vec_t v;
      v.we = w[0]; v.wa = a[4:0]; v.wd = d; v.iss = s[0]; v.ia = ia[4:0];
      v.ra1 = r1[4:0]; v.ra2 = r2[4:0]; v.e_rd1 = e1; v.e_h1 = h1[0];
      v.e_rd2 = e2; v.e_h2 = h2[0]; v.e_cnt = c;
      return v;
   endfunction

   vec_t tbl [18];

   initial begin
      // scoreboard: issue r3, two idle cycles, writeback r3
      tbl[0]  = mk(0, 0, 0,            1, 3, 0, 3, 0,            0, 0,     0, 0);
      tbl[1]  = mk(0, 0, 0,            0, 0, 0, 3, 0,            0, 0,     1, 0);
      tbl[2]  = mk(0, 0, 0,            0, 0, 0, 3, 0,            0, 0,     1, 1);
      tbl[3]  = mk(1, 3, 32'hA5,       0, 0, 0, 3, 0,            0, 32'hA5, 0, 1);
      tbl[4]  = mk(0, 0, 0,            0, 0, 0, 3, 0,            0, 32'hA5, 0, 1);
      tbl[5]  = mk(0, 0, 0,            0, 0, 0, 3, 0,            0, 32'hA5, 0, 0);
      // zero register: write then issue r0
      tbl[6]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 3, 0,            0, 32'hA5, 0, 0);
      tbl[7]  = mk(0, 0, 0,            1, 0, 0, 3, 0,            0, 32'hA5, 0, 0);
      tbl[8]  = mk(0, 0, 0,            0, 0, 0, 3, 0,            0, 32'hA5, 0, 0);
      tbl[9]  = mk(0, 0, 0,            0, 0, 0, 3, 0,            0, 32'hA5, 0, 0);
      // bypass of r7
      tbl[10] = mk(1, 7, 32'h12345678, 0, 0, 7, 3, 32'h12345678, 0, 32'hA5, 0, 0);
      tbl[11] = mk(0, 0, 0,            0, 0, 7, 3, 32'h12345678, 0, 32'hA5, 0, 0);
      // simultaneous issue and write of r9, then writeback
      tbl[12] = mk(1, 9, 32'h99,       1, 9, 9, 3, 32'h99,       0, 32'hA5, 0, 0);
      tbl[13] = mk(0, 0, 0,            0, 0, 9, 3, 32'h99,       1, 32'hA5, 0, 0);
      tbl[14] = mk(0, 0, 0,            0, 0, 9, 3, 32'h99,       1, 32'hA5, 0, 1);
      tbl[15] = mk(1, 9, 32'h11,       0, 0, 9, 3, 32'h11,       0, 32'hA5, 0, 1);
      tbl[16] = mk(0, 0, 0,            0, 0, 9, 3, 32'h11,       0, 32'hA5, 0, 1);
      tbl[17] = mk(0, 0, 0,            0, 0, 9, 3, 32'h11,       0, 32'hA5, 0, 0);
   end

   // ---------------- test sequence ----------------
   initial begin
      rst_n = 1'b0;
      ra1 = '0; ra2 = '0;
      idle();
      m_reset();

      // reset state
      ra1 = 5'd5; ra2 = 5'd31;
      #1;
      chk("reset_rd1_a",  rd1_a, 32'h0);
      chk("reset_haz1_a", 32'(haz1_a), 32'h0);
      chk("reset_cnt_a",  32'(cnt_a), 32'h0);
      check_all();
      tick();
      rst_n = 1'b1;

      // table vectors
      for (int i = 0; i < 18; i++) begin
         we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
         iss = tbl[i].iss; iss_addr = tbl[i].ia;
         ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
         #2;
         chk($sformatf("tbl%0d_rd1", i),  rd1_a,       tbl[i].e_rd1);
         chk($sformatf("tbl%0d_haz1", i), 32'(haz1_a), 32'(tbl[i].e_h1));
         chk($sformatf("tbl%0d_rd2", i),  rd2_a,       tbl[i].e_rd2);
         chk($sformatf("tbl%0d_haz2", i), 32'(haz2_a), 32'(tbl[i].e_h2));
         chk($sformatf("tbl%0d_cnt", i),  32'(cnt_a),  tbl[i].e_cnt);
         check_all();
         tick();
      end

      // mid-operation asynchronous reset with a load in flight
      we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; iss = 1'b1; iss_addr = 5'd4;
      ra1 = 5'd5; ra2 = 5'd4;
      #2; check_all(); tick();
      idle();
      #2;
      chk("rst_pre_rd1",  rd1_a, 32'hDEADBEEF);
      chk("rst_pre_haz2", 32'(haz2_a), 32'h1);
      check_all(); tick();
      #2;
      chk("rst_pre_cnt", 32'(cnt_a), 32'h1);
      rst_n = 1'b0;
      #1;
      m_reset();
      chk("rst_async_rd1_a", rd1_a, 32'h0);
      chk("rst_async_rd1_b", rd1_b, 32'h0);
      chk("rst_async_haz2",  32'(haz2_a), 32'h0);
      chk("rst_async_cnt_a", 32'(cnt_a), 32'h0);
      chk("rst_async_cnt_b", 32'(cnt_b), 32'h0);
      check_all(); tick();
      rst_n = 1'b1;
      // plain writeback to a register no longer pending
      we = 1'b1; wa = 5'd4; wd = 32'h44; ra1 = 5'd4;
      #2;
      chk("post_rst_byp_rd1", rd1_a, 32'h44);
      chk("post_rst_haz1",    32'(haz1_a), 32'h0);
      check_all(); tick();
      idle();
      #2;
      chk("post_rst_rd1_b", rd1_b, 32'h44);
      chk("post_rst_cnt",   32'(cnt_a), 32'h0);
      check_all(); tick();

      // out-of-range address on the 24-deep instance
      we = 1'b1; wa = 5'd30; wd = 32'hCAFEF00D; iss = 1'b1; iss_addr = 5'd30;
      ra1 = 5'd30; ra2 = 5'd6;
      #2;
      chk("oor_rd1_b",  rd1_b, 32'h0);
      chk("oor_haz1_b", 32'(haz1_b), 32'h0);
      check_all(); tick();
      idle();
      #2;
      chk("oor_rd1_b_after",  rd1_b, 32'h0);
      chk("oor_haz1_b_after", 32'(haz1_b), 32'h0);
      chk("oor_rd1_a",        rd1_a, 32'hCAFEF00D);
      chk("oor_haz1_a",       32'(haz1_a), 32'h1);
      check_all(); tick();
      #2;
      chk("oor_cnt_b", 32'(cnt_b), 32'h0);
      chk("oor_cnt_a", 32'(cnt_a), 32'h1);
      tick();
      for (int i = 0; i < 32; i++) begin
         ra1 = 5'(i); ra2 = 5'(31 - i);
         #2; check_all(); tick();
      end

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         we       = ($urandom_range(0, 1) == 1);
         wa       = 5'($urandom_range(0, 31));
         wd       = $urandom;
         iss      = ($urandom_range(0, 2) == 0);
         iss_addr = 5'($urandom_range(0, 31));
         ra1      = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         ra2      = ($urandom_range(0, 3) == 0) ? iss_addr : 5'($urandom_range(0, 31));
         #2; check_all(); tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised 2-read/1-write register file with a per-register pending-write scoreboard. It is the next-generation replacement for the single-cycle CPU's register file.
- Adds configurable width and depth, an optional hardwired zero register, and write-to-read bypass.
- Adds asynchronous clear of all registers.
- Tracks in-flight loads, so the pipelined datapath can detect read-after-write hazards and stall.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers (2..64)
- ADDR_W, $clog2(DEPTH), address width (derived, do not override)
- ZERO_REG, 1, if 1 register 0 reads as 0, ignores writes, is never pending
- BYPASS, 1, if 1 a same-cycle write is forwarded to matching read ports

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  sole clock, rising edge
  - rst_n  in  1  asynchronous active-low reset
- Read ports:
  - ra1, ra2  in  ADDR_W  read addresses
  - rd1, rd2  out  DATA_W  read data, combinational
  - haz1, haz2  out  1  read register is pending and not being written this cycle
- Write port:
  - we  in  1  write enable (writeback)
  - wa  in  ADDR_W  write address
  - wd  in  DATA_W  write data
- Issue port:
  - iss  in  1  mark register as pending (load issued)
  - iss_addr  in  ADDR_W  register to mark pending
- Status:
  - pend_cnt  out  ADDR_W+1  number of pending registers, registered

## Operation
- Storage: DEPTH x DATA_W flops, plus a DEPTH-bit pending vector.
- Read: rdN = regs[raN].
  - If BYPASS=1 and we=1 and wa==raN (and the address is writable), rdN = wd.
  - If ZERO_REG=1 and raN==0, rdN = 0 regardless of bypass.
- Write: on a rising clk edge with we=1, regs[wa] <= wd.
  - Ignored if ZERO_REG=1 and wa==0.
  - Ignored if wa >= DEPTH.
- Pending bit update per edge, in priority order:
  1. iss=1: pending[iss_addr] set. It stays set even if the same edge writes that register, because the new issue wins.
  2. Otherwise, we=1 clears pending[wa].
  - iss to register 0 with ZERO_REG=1, or to an address >= DEPTH, is ignored.
- Hazard: hazN = pending[raN] & ~(we & wa==raN).
  - With BYPASS=0, the we term is dropped: hazN = pending[raN].
  - hazN is forced to 0 for the zero register.
- Reads of an address >= DEPTH return 0 with haz=0.
- pend_cnt: the population count of pending, registered one cycle after the pending update.

## Timing
- Reset (rst_n=0, asynchronous):
  - all regs = 0, pending = 0, pend_cnt = 0.
  - Therefore rd1 = rd2 = 0 and haz1 = haz2 = 0 while in reset.
  - Deassertion is sampled synchronously; the first write can occur on the first rising edge with rst_n=1.
- Reset mid-operation: all pending loads are dropped. A later we to a register that is not pending is a plain write with no error.
- Read latency: 0 cycles (combinational). With BYPASS=0, a write becomes visible on rd one cycle after the edge.
- Issue-to-hazard: iss at edge N, so haz is visible from edge N onwards for reads of that address.
- Writeback-to-clear:
  - BYPASS=1: haz drops in the same cycle as we.
  - BYPASS=0: haz drops after the edge.
- pend_cnt lags pending by exactly one cycle; maximum value is DEPTH (DEPTH-1 when ZERO_REG=1).
- Write to a register that is not pending: performed normally; the pending vector is unchanged.

## Structure
- Package reg_file_pkg holds:
  - default DATA_W/DEPTH constants
  - a localparam function for popcount width
  - a typedef for the register address
- Sub-module reg_scoreboard holds the pending vector, issue/clear priority, hazard generation and pend_cnt.
- The top holds the storage array, write decode and read/bypass muxes.

## Test plan
- Reset: write 0xDEADBEEF to r5, then pulse rst_n low mid-cycle.
  - Required: rd1 (ra1=5) = 0 immediately, asynchronously.
  - Required: pend_cnt = 0.
- Bypass: BYPASS=1, we=1, wa=7, wd=0x12345678, ra1=7.
  - Required: rd1 = 0x12345678 in the same cycle.
  - Required: after the edge, with we=0, rd1 is unchanged.
- Zero register: ZERO_REG=1, write 0xFFFFFFFF to r0, then iss to r0.
  - Required: rd1 = 0, haz1 = 0, pend_cnt = 0.
- Scoreboard: iss r3, then 2 idle cycles, then we r3 = 0xA5.
  - Required: haz2 (ra2=3) = 1 for both idle cycles.
  - Required: haz2 = 0 in the we cycle, and rd2 = 0xA5.
  - Required: pend_cnt sequence 0, 1, 1, 1, 0.
- Simultaneous issue and write: iss=1 and we=1 on the same address r9.
  - Required: after the edge, regs[9] = wd and pending[9] = 1 (haz=1).
- Out-of-range address: DEPTH=24, we=1, wa=30, then read ra1=30.
  - Required: rd1 = 0, haz1 = 0, and no other register is modified.
